// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4-to-1 mux. It steps s1/s0 through the enabled channels,
// waits DWELL cycles on each, then samples mux_o into the matching bit of word.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] en_mask,
   input  logic       mux_o,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic       done,
   output logic [3:0] word
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [3:0] RELOAD = 4'(DWELL - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] mask;
   logic [1:0] sel;
   logic [1:0] first_ch;
   logic [1:0] next_ch;
   logic       next_valid;

   assign s1 = sel[1];
   assign s0 = sel[0];

   // Pick the lowest enabled channel at launch, and the next enabled channel above
   // the current one during a scan. Both loops run downward so the lowest index wins.
   always_comb begin
      first_ch   = '0;
      next_ch    = sel;
      next_valid = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (en_mask[i])
            first_ch = 2'(i);
         if (mask[i] && (i > int'(sel))) begin
            next_valid = 1'b1;
            next_ch    = 2'(i);
         end
      end
   end

   // done is raised on the edge that enters DONE, so it is high for exactly the one
   // cycle spent there. The selects are only touched at launch and on sample edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         word  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  mask <= en_mask;
                  word <= '0;
                  if (en_mask != 4'b0000) begin
                     sel   <= first_ch;
                     cnt   <= RELOAD;
                     busy  <= 1'b1;
                     state <= SCAN;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            SCAN: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  word[sel] <= mux_o;
                  if (next_valid) begin
                     sel <= next_ch;
                     cnt <= RELOAD;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a DWELL=2 instance gets directed and random scans, and
// a DWELL=1 instance gets back-to-back scans. The mux is modelled as d[{s1,s0}].
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [3:0] en_mask = 4'b0000;
   logic [3:0] d = 4'b0000;

   logic       mux_o_a, s1_a, s0_a, busy_a, done_a;
   logic [3:0] word_a;
   logic       mux_o_b, s1_b, s0_b, busy_b, done_b;
   logic [3:0] word_b;

   int         checks = 0;
   int         failures = 0;
   logic [1:0] exp_sel_a = 2'b00;

   assign mux_o_a = d[{s1_a, s0_a}];
   assign mux_o_b = d[{s1_b, s0_b}];

   mux_scan_ctrl #(.DWELL(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .en_mask(en_mask), .mux_o(mux_o_a),
      .s1(s1_a), .s0(s0_a), .busy(busy_a), .done(done_a), .word(word_a)
   );

   mux_scan_ctrl #(.DWELL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .en_mask(en_mask), .mux_o(mux_o_b),
      .s1(s1_b), .s0(s0_b), .busy(busy_b), .done(done_b), .word(word_b)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] m, input logic [3:0] dv, input logic st);
      en_mask = m;
      d       = dv;
      start_a = st;
   endtask

   // Expected behaviour comes from the channel list: the select for cycle offset t is
   // chans[t/DWELL], done comes n*DWELL cycles after launch, and word = mask & d.
   task automatic runScan(input string name, input logic [3:0] m, input logic [3:0] dv,
                          input bit disturb);
      int chans[$];
      int total;
      for (int i = 0; i < 4; i++)
         if (m[i]) chans.push_back(i);
      total = chans.size() * 2;
      applyStimulus(m, dv, 1'b1);
      tick();
      start_a = 1'b0;
      if (total == 0) begin
         checkOutput({name, "_empty_busy_done"}, {2'b00, busy_a, done_a}, 4'b0001);
         checkOutput({name, "_empty_word"}, word_a, 4'b0000);
         checkOutput({name, "_empty_sel"}, {2'b00, s1_a, s0_a}, {2'b00, exp_sel_a});
         tick();
         checkOutput({name, "_empty_after"}, {2'b00, busy_a, done_a}, 4'b0000);
         return;
      end
      for (int t = 0; t < total; t++) begin
         checkOutput($sformatf("%s_sel_t%0d", name, t), {2'b00, s1_a, s0_a}, 4'(chans[t / 2]));
         checkOutput($sformatf("%s_busy_t%0d", name, t), {2'b00, busy_a, done_a}, 4'b0010);
         if (disturb) begin
            start_a = 1'($urandom_range(0, 1));
            en_mask = 4'($urandom);
         end
         tick();
      end
      start_a   = 1'b0;
      exp_sel_a = 2'(chans[chans.size() - 1]);
      checkOutput({name, "_done_pulse"}, {2'b00, busy_a, done_a}, 4'b0001);
      checkOutput({name, "_word"}, word_a, m & dv);
      checkOutput({name, "_sel_last"}, {2'b00, s1_a, s0_a}, {2'b00, exp_sel_a});
      tick();
      checkOutput({name, "_idle_flags"}, {2'b00, busy_a, done_a}, 4'b0000);
      checkOutput({name, "_idle_word"}, word_a, m & dv);
      checkOutput({name, "_idle_sel"}, {2'b00, s1_a, s0_a}, {2'b00, exp_sel_a});
   endtask

   initial begin
      logic [3:0] dv;
      logic [3:0] nd;

      // Reset values appear without any clock edge.
      #1;
      checkOutput("reset_flags", {s1_a, s0_a, busy_a, done_a}, 4'b0000);
      checkOutput("reset_word", word_a, 4'b0000);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      runScan("full_1010", 4'b1111, 4'b1010, 1'b0);
      runScan("mask_0101", 4'b0101, 4'b1111, 1'b0);
      runScan("mask_0000", 4'b0000, 4'b1111, 1'b0);
      runScan("disturb", 4'b1011, 4'b0110, 1'b1);

      // Asynchronous reset mid-scan, after channel 0 has been sampled.
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      tick();
      start_a = 1'b0;
      tick();
      tick();
      checkOutput("midscan_word", word_a, 4'b0001);
      checkOutput("midscan_sel", {2'b00, s1_a, s0_a}, 4'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_flags", {s1_a, s0_a, busy_a, done_a}, 4'b0000);
      checkOutput("async_rst_word", word_a, 4'b0000);
      tick();
      checkOutput("rst_no_done1", {2'b00, busy_a, done_a}, 4'b0000);
      rst_n = 1'b1;
      exp_sel_a = 2'b00;
      tick();
      checkOutput("rst_no_done2", {2'b00, busy_a, done_a}, 4'b0000);
      runScan("after_rst", 4'b1111, 4'b1010, 1'b0);

      for (int r = 0; r < 8; r++)
         runScan($sformatf("rand%0d", r), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

      // DWELL=1 with start held: a new scan every 6 cycles, each word tracking d.
      en_mask = 4'b1111;
      dv      = 4'($urandom);
      d       = dv;
      start_b = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         for (int t = 0; t < 4; t++) begin
            checkOutput($sformatf("b2b%0d_sel_t%0d", s, t), {2'b00, s1_b, s0_b}, 4'(t));
            checkOutput($sformatf("b2b%0d_busy_t%0d", s, t), {2'b00, busy_b, done_b}, 4'b0010);
            tick();
         end
         checkOutput($sformatf("b2b%0d_done", s), {2'b00, busy_b, done_b}, 4'b0001);
         checkOutput($sformatf("b2b%0d_word", s), word_b, dv);
         nd = 4'($urandom);
         d  = nd;
         tick();
         checkOutput($sformatf("b2b%0d_idle", s), {2'b00, busy_b, done_b}, 4'b0000);
         checkOutput($sformatf("b2b%0d_hold", s), word_b, dv);
         dv = nd;
         if (s == 2)
            start_b = 1'b0;
         tick();
      end
      checkOutput("b2b_stopped", {2'b00, busy_b, done_b}, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
